// File: rtl/sar_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sar_seq_ctrl : synchronous SAR conversion sequencer.
//
// Drives the sample strobe (CKSB), the one-hot bit-finish strobes (CF, MSB
// first) and the dynamic comparator clock (CMP_CLK). It reads the comparator
// decision from CMP_P/CMP_N and builds the result word in DOUT. The result is
// offered to the back end on a DVALID/DREADY handshake.
//
// Ports
//   CLK      in   system clock
//   RST      in   asynchronous active-high reset
//   START    in   conversion request, sampled only in IDLE
//   CMP_P    in   comparator positive decision
//   CMP_N    in   comparator negative decision (resolved when != CMP_P)
//   CONT     in   (SAR_CONT_EN only) on handshake, restart sampling directly
//   CKSB     out  0 = sample/reset CDAC switches, 1 = convert
//   CF       out  [NBIT] one-hot bit-finish strobes, high only in LATCH
//   CMP_CLK  out  comparator clock, high only in CMP
//   DOUT     out  [NBIT] conversion result, MSB = bit NBIT-1
//   DVALID   out  result valid
//   DREADY   in   result accepted when DVALID && DREADY
//   TOERR    out  sticky: at least one bit timed out in this result
//   BUSY     out  high in SAMPLE, CMP, LATCH
//
// Optional feature macro: SAR_CONT_EN (adds CONT, continuous conversion).
//
// Every output is a flop. Its next value is decoded from the next state, so the
// outputs track the state register without a combinational path from inputs.
// -----------------------------------------------------------------------------
module sar_seq_ctrl #(
  parameter int NBIT        = 8,
  parameter int SAMPLE_CYC  = 2,
  parameter int CMP_TIMEOUT = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            CMP_P,
  input  logic            CMP_N,
`ifdef SAR_CONT_EN
  input  logic            CONT,
`endif
  output logic            CKSB,
  output logic [NBIT-1:0] CF,
  output logic            CMP_CLK,
  output logic [NBIT-1:0] DOUT,
  output logic            DVALID,
  input  logic            DREADY,
  output logic            TOERR,
  output logic            BUSY
);

  localparam int IW   = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int CMAX = (SAMPLE_CYC > CMP_TIMEOUT) ? SAMPLE_CYC : CMP_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] IDX_MSB = IW'(NBIT - 1);
  localparam logic [CW-1:0] SMP_END = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] TO_END  = CW'(CMP_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_CMP    = 3'd2;
  localparam logic [2:0] S_LATCH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]      r_state, w_nstate;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;     // sample counter / per-bit wait counter
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            w_resolved;
  logic            w_timeout;
  logic            w_restart;            // DONE handshake goes straight to SAMPLE

  logic            r_cksb, r_cmp_clk, r_dvalid, r_toerr, r_busy;
  logic [NBIT-1:0] r_cf, r_dout;

  assign w_resolved = CMP_P ^ CMP_N;

`ifdef SAR_CONT_EN
  assign w_restart = CONT;
`else
  assign w_restart = 1'b0;
`endif

  always_comb begin
    w_nstate  = r_state;
    w_cnt_nxt = r_cnt;
    w_idx_nxt = r_idx;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_nstate  = S_SAMPLE;
          w_cnt_nxt = '0;
        end
      end
      S_SAMPLE: begin
        if (r_cnt == SMP_END) begin
          w_nstate  = S_CMP;
          w_cnt_nxt = '0;
          w_idx_nxt = IDX_MSB;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_CMP: begin
        // A decision arriving on the last allowed cycle still wins over timeout.
        if (w_resolved) begin
          w_nstate  = S_LATCH;
          w_cnt_nxt = '0;
        end else if (r_cnt == TO_END) begin
          w_nstate  = S_LATCH;
          w_cnt_nxt = '0;
          w_timeout = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_LATCH: begin
        if (r_idx == '0) begin
          w_nstate = S_DONE;
        end else begin
          w_nstate  = S_CMP;
          w_idx_nxt = r_idx - IW'(1);
        end
      end
      S_DONE: begin
        if (r_dvalid && DREADY) begin
          w_idx_nxt = IDX_MSB;
          w_cnt_nxt = '0;
          w_nstate  = w_restart ? S_SAMPLE : S_IDLE;
        end
      end
      default: begin
        w_nstate  = S_IDLE;
        w_cnt_nxt = '0;
        w_idx_nxt = IDX_MSB;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= IDX_MSB;
      r_cksb    <= 1'b0;
      r_cf      <= '0;
      r_cmp_clk <= 1'b0;
      r_dout    <= '0;
      r_dvalid  <= 1'b0;
      r_toerr   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_cksb    <= (w_nstate == S_CMP) || (w_nstate == S_LATCH);
      r_cmp_clk <= (w_nstate == S_CMP);
      r_dvalid  <= (w_nstate == S_DONE);
      r_busy    <= (w_nstate == S_SAMPLE) || (w_nstate == S_CMP) ||
                   (w_nstate == S_LATCH);

      // The CF strobe for the current bit rises on the same edge that captures
      // the comparator into DOUT, so the switch and the result word agree.
      r_cf <= '0;
      if (w_nstate == S_LATCH) r_cf[r_idx] <= 1'b1;

      if ((w_nstate == S_SAMPLE) && (r_state != S_SAMPLE)) begin
        r_dout  <= '0;
        r_toerr <= 1'b0;
      end else if ((r_state == S_CMP) && (w_nstate == S_LATCH)) begin
        r_dout[r_idx] <= CMP_P;
        if (w_timeout) r_toerr <= 1'b1;
      end
    end
  end

  assign CKSB    = r_cksb;
  assign CF      = r_cf;
  assign CMP_CLK = r_cmp_clk;
  assign DOUT    = r_dout;
  assign DVALID  = r_dvalid;
  assign TOERR   = r_toerr;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_seq_ctrl : directed bench for sar_seq_ctrl (default build, NBIT=8,
// SAMPLE_CYC=2, CMP_TIMEOUT=4).
//
// Each table record describes one conversion. It holds the comparator MSB-first
// decision pattern and a per-bit count of unresolved cycles that come before the
// decision (00, or 11 where u11 is set). It also holds the hand-computed DOUT,
// TOERR and START-to-DVALID latency. Latency counts rising edges from the edge
// that samples START (edge 1) to the edge that raises DVALID.
// -----------------------------------------------------------------------------
module tb_sar_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       CMP_P = 1'b0;
  logic       CMP_N = 1'b0;
  logic       DREADY = 1'b0;
  logic       CKSB, CMP_CLK, DVALID, TOERR, BUSY;
  logic [7:0] CF, DOUT;

  sar_seq_ctrl #(.NBIT(8), .SAMPLE_CYC(2), .CMP_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CMP_P(CMP_P), .CMP_N(CMP_N),
    .CKSB(CKSB), .CF(CF), .CMP_CLK(CMP_CLK), .DOUT(DOUT), .DVALID(DVALID),
    .DREADY(DREADY), .TOERR(TOERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]      pat;
    logic [7:0][2:0] dly;
    logic [7:0]      u11;
    logic [7:0]      exp_dout;
    logic            exp_to;
    logic [7:0]      exp_lat;
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One conversion with a reactive comparator model.
  task automatic run_conv(input vec_t v, input string nm);
    int cyc, b, k, ns, expk;
    logic done;
    cyc = 0; b = 7; k = 0; ns = 0; done = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    while (!done && cyc < 200) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      START = 1'b0;
      if (BUSY && !CKSB) ns++;
      if (CF != 8'h00) begin
        expk = (int'(v.dly[b]) >= 4) ? 4 : int'(v.dly[b]) + 1;
        chk($sformatf("%s_cf_b%0d", nm, b), {23'd0, CMP_CLK, CF}, {23'd0, 1'b0, 8'(1 << b)});
        chk($sformatf("%s_cmpcyc_b%0d", nm, b), k, expk);
        b--;
        k = 0;
        {CMP_P, CMP_N} = 2'b00;
      end else if (CMP_CLK) begin
        if (k < int'(v.dly[b])) {CMP_P, CMP_N} = v.u11[b] ? 2'b11 : 2'b00;
        else                    {CMP_P, CMP_N} = {v.pat[b], ~v.pat[b]};
        k++;
      end
      if (DVALID) done = 1'b1;
    end
    {CMP_P, CMP_N} = 2'b00;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_lat"}, cyc, v.exp_lat);
    chk({nm, "_dout"}, DOUT, v.exp_dout);
    chk({nm, "_toerr"}, TOERR, v.exp_to);
    chk({nm, "_smpcyc"}, ns, 2);
  endtask

  // Handshake: DVALID must drop on the cycle after DREADY is seen.
  task automatic ack(input string nm);
    DREADY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    DREADY = 1'b0;
    chk({nm, "_ack"}, {DVALID, BUSY, CKSB}, 3'b000);
  endtask

  initial begin
    tbl[0] = '{pat:8'hB2, dly:'0, u11:8'h00, exp_dout:8'hB2, exp_to:1'b0, exp_lat:8'd19};
    tbl[1] = '{pat:8'hFF, dly:'0, u11:8'h00, exp_dout:8'hF7, exp_to:1'b1, exp_lat:8'd22};
    tbl[1].dly[3] = 3'd4;                     // bit 3 holds 00 -> timeout, DOUT[3]=0
    tbl[2] = '{pat:8'h5A, dly:'0, u11:8'h00, exp_dout:8'h5A, exp_to:1'b0, exp_lat:8'd19};
    tbl[3] = '{pat:8'h08, dly:'0, u11:8'h08, exp_dout:8'h08, exp_to:1'b0, exp_lat:8'd21};
    tbl[3].dly[3] = 3'd2;                     // 11,11 then 10 -> 3 CMP cycles, bit=1
    tbl[4] = '{pat:8'h00, dly:'0, u11:8'h00, exp_dout:8'h00, exp_to:1'b0, exp_lat:8'd19};
    tbl[5] = '{pat:8'hFF, dly:{8{3'd1}}, u11:8'h00, exp_dout:8'hFF, exp_to:1'b0, exp_lat:8'd27};
    tbl[6] = '{pat:8'h00, dly:'0, u11:8'h01, exp_dout:8'h01, exp_to:1'b1, exp_lat:8'd22};
    tbl[6].dly[0] = 3'd5;                     // 11 held to timeout -> CMP_P=1 captured
    tbl[7] = '{pat:8'h80, dly:'0, u11:8'h00, exp_dout:8'h80, exp_to:1'b0, exp_lat:8'd22};
    tbl[7].dly[7] = 3'd3;                     // resolves on the 4th cycle: no timeout

    // Reset state, then 10 idle cycles.
    #2;
    chk("rst_state", {CKSB, CF, CMP_CLK, DOUT, DVALID, TOERR, BUSY}, '0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk($sformatf("idle_%0d", i), {CKSB, CF, CMP_CLK, DVALID, TOERR, BUSY}, '0);
    end

    // DREADY while nothing is valid has no effect.
    DREADY = 1'b1;
    repeat (3) @(negedge CLK);
    DREADY = 1'b0;
    chk("dready_idle", {DVALID, BUSY}, 2'b00);

    for (int i = 0; i < NV; i++) begin
      run_conv(tbl[i], $sformatf("v%0d", i));
      if (i == 2) begin
        // Back end stalls; START pulses must be ignored while the result waits.
        for (int j = 0; j < 20; j++) begin
          START = (j % 3 == 0);
          @(posedge CLK);
          @(negedge CLK);
          chk($sformatf("stall_%0d", j), {DVALID, DOUT, CKSB, BUSY, CMP_CLK, CF},
              {1'b1, tbl[2].exp_dout, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        START = 1'b0;
      end
      ack($sformatf("v%0d", i));
    end

    // Reset asserted during the CMP phase of bit 5.
    begin
      logic seen6;
      int   n;
      seen6 = 1'b0;
      n = 0;
      {CMP_P, CMP_N} = 2'b10;
      @(negedge CLK);
      START = 1'b1;
      while (!(seen6 && CMP_CLK) && n < 100) begin
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        n++;
        if (CF[6]) seen6 = 1'b1;
      end
      chk("mid_reach_b5", {seen6, CMP_CLK, BUSY, DOUT}, {3'b111, 8'hC0});
      #2 RST = 1'b1;
      #1 chk("mid_rst", {CKSB, CF, CMP_CLK, DOUT, DVALID, TOERR, BUSY}, '0);
      {CMP_P, CMP_N} = 2'b00;
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("post_rst_idle", {CKSB, CF, CMP_CLK, DVALID, BUSY}, '0);
    end

    // A full conversion after the aborted one.
    run_conv(tbl[0], "after_rst");
    ack("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
